bubble_sort_stage_sequencer: RTL and testbench
==============================================

// Module: bubble_sort_stage_sequencer
// PURPOSE
//  Top-level controller sequencing the three pipelined loop sub-blocks of bubble_sort: LOAD (once), SORT (one call per pass), STORE (once).
//  - Exposes an ap_ctrl_hs interface upward and drives start/ready/done handshakes to each child.
//  - Terminates early when a sort pass reports no swaps.
//  - Replaces the generic HLS FSM stepping between the loop instances.
// PARAMETERS
//  PASS_W      8   width of pass_count / pass_idx
//  EARLY_EXIT  1   1: a pass with sort_swapped=0 ends sorting; 0: always run pass_count passes
//  CNT_W       32  width of cycle_count (used only with SEQ_PERF_CNT_EN)
// PORTS
//  clock        in   1       system clock, all logic on posedge
//  reset        in   1       synchronous, active-high
//  ap_start     in   1       request a sort; sampled only in IDLE
//  ap_done      out  1       1-cycle pulse, sort complete
//  ap_ready     out  1       equals ap_done
//  ap_idle      out  1       high only in IDLE
//  pass_count   in   PASS_W  max sort passes, latched when ap_start accepted
//  load_start   out  1       LOAD child ap_start
//  load_ready   in   1       LOAD child ap_ready
//  load_done    in   1       LOAD child ap_done
//  sort_start   out  1       SORT child ap_start
//  sort_ready   in   1       SORT child ap_ready
//  sort_done    in   1       SORT child ap_done
//  sort_swapped in   1       pass made >=1 swap; valid only when sort_done=1
//  store_start  out  1       STORE child ap_start
//  store_ready  in   1       STORE child ap_ready
//  store_done   in   1       STORE child ap_done
//  pass_idx     out  PASS_W  index of current/next SORT pass
//  early_exit   out  1       sticky: last run ended on a no-swap pass; cleared on next accepted ap_start
// BEHAVIOUR
//  - Reset values: state=IDLE; ap_done=ap_ready=0; ap_idle=1; all *_start=0; pass_idx=0; early_exit=0; latched count=0.
//  - States: IDLE, LOAD, SORT, STORE, DONE.
//  - IDLE:
//    - ap_start=1 at edge k: latch pass_count, clear pass_idx and early_exit; state=LOAD in cycle k+1.
//  - Child handshake (all three children):
//    - x_start = (state==X) && !taken.
//    - taken is set when x_ready|x_done is sampled high, and cleared on state entry and on each new SORT pass.
//    - x_done may arrive with or after x_ready. x_done is the only exit condition.
//    - x_done in any other state is ignored.
//  - LOAD, on load_done: go to SORT if latched count != 0, else STORE.
//  - SORT, on sort_done: pass_idx += 1, then:
//    - If pass_idx == count-1, go to STORE.
//    - Else if EARLY_EXIT && !sort_swapped, set early_exit=1 and go to STORE.
//    - Else stay in SORT with taken cleared, so sort_start re-asserts the next cycle.
//  - STORE, on store_done: go to DONE.
//  - DONE: ap_done=ap_ready=1 for exactly 1 cycle, then IDLE. ap_start is never sampled in DONE.
//  - Timing: the minimum gap between consecutive runs is 1 IDLE cycle. The sequencer holds any state indefinitely while a child stalls.
//  - Arithmetic:
//    - pass_idx never wraps: the terminal compare fires before overflow.
//    - count=2^PASS_W-1 runs that many passes.
//  - Reset mid-operation: next cycle is IDLE with reset values. Children share the reset.
//  - Outputs: all outputs are derived only from registered state; there is no comb path from inputs to outputs.
// CONFIGURATION
//  - SEQ_PERF_CNT_EN defined:
//    - Adds port cycle_count (out, CNT_W).
//    - Cleared when ap_start is accepted, then +1 each cycle state!=IDLE.
//    - Holds its value in IDLE and saturates at all-ones. Reset value 0.
//  - SEQ_PERF_CNT_EN undefined: no port, no counter logic. Behaviour otherwise identical.
// TESTING
//  Child model: x_ready and x_done both asserted on the 3rd consecutive cycle of x_start.
//  1. pass_count=3, sort_swapped=1 on every pass:
//     - ap_start accepted at cycle 0 -> LOAD cycles 1-3, SORT 4-12 (3 sort_start bursts), STORE 13-15.
//     - ap_done=1 at cycle 16 only; early_exit=0; cycle_count=16.
//  2. pass_count=5, sort_swapped=0 on pass 0:
//     - Exactly 1 SORT call; early_exit=1; pass_idx=1; ap_done at cycle 10.
//     - With EARLY_EXIT=0: 5 calls; ap_done at cycle 22.
//  3. pass_count=0:
//     - sort_start never asserts; STORE cycles 4-6; ap_done at cycle 7; cycle_count=7.
//  4. Stall: LOAD child asserts load_ready at cycle 1 and load_done at cycle 12:
//     - load_start high only in cycle 1; state LOAD held through cycle 12.
//     - ap_done at cycle 25 (pass_count=3).
//  5. ap_start held high continuously:
//     - ap_done at 16, ap_idle=1 at 17, load_start=1 at 18.
//     - early_exit cleared at the second acceptance.
//  6. reset pulsed for 1 cycle during the 2nd SORT pass:
//     - Next cycle: all *_start=0, ap_idle=1, pass_idx=0, early_exit=0, cycle_count=0.
//     - A new ap_start then repeats scenario 1 timing exactly.

Source files
------------

// File: rtl/bubble_sort_stage_sequencer_if.sv
// Handshake bundle between the sort sequencer, its caller and its children.
// master: sequencer side (ap_* outputs, child starts); slave: environment.
interface bubble_sort_stage_sequencer_if #(
    parameter int PASS_W = 8
);
    logic              ap_start;
    logic              ap_done;
    logic              ap_ready;
    logic              ap_idle;
    logic [PASS_W-1:0] pass_count;
    logic              load_start;
    logic              load_ready;
    logic              load_done;
    logic              sort_start;
    logic              sort_ready;
    logic              sort_done;
    logic              sort_swapped;
    logic              store_start;
    logic              store_ready;
    logic              store_done;
    logic [PASS_W-1:0] pass_idx;
    logic              early_exit;

    modport master (
        input  ap_start, pass_count,
        input  load_ready, load_done,
        input  sort_ready, sort_done, sort_swapped,
        input  store_ready, store_done,
        output ap_done, ap_ready, ap_idle,
        output load_start, sort_start, store_start,
        output pass_idx, early_exit
    );

    modport slave (
        output ap_start, pass_count,
        output load_ready, load_done,
        output sort_ready, sort_done, sort_swapped,
        output store_ready, store_done,
        input  ap_done, ap_ready, ap_idle,
        input  load_start, sort_start, store_start,
        input  pass_idx, early_exit
    );
endinterface

// File: rtl/bubble_sort_stage_sequencer.sv
// Sequences bubble_sort LOAD once, SORT once per pass, STORE once.
// Ports: clock, reset (sync, active-high), bus (ap_ctrl_hs + child
// handshakes, pass_count/pass_idx/early_exit); with SEQ_PERF_CNT_EN
// defined, cycle_count reports cycles spent outside IDLE per run.
module bubble_sort_stage_sequencer #(
    parameter int PASS_W     = 8,
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    bubble_sort_stage_sequencer_if.master   bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                cycle_count
`endif
);

    if (PASS_W < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("PASS_W and CNT_W must be positive");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SORT,
        S_STORE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              taken_q, taken_d;
    logic [PASS_W-1:0] cnt_q, cnt_d;
    logic [PASS_W-1:0] pidx_q, pidx_d;
    logic              ee_q, ee_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            taken_q <= 1'b0;
            cnt_q   <= '0;
            pidx_q  <= '0;
            ee_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
            pidx_q  <= pidx_d;
            ee_q    <= ee_d;
        end
    end

    // taken remembers that the current child call was accepted, so
    // x_start drops after the child's ready even while done is pending.
    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        cnt_d   = cnt_q;
        pidx_d  = pidx_q;
        ee_d    = ee_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    cnt_d   = bus.pass_count;
                    pidx_d  = '0;
                    ee_d    = 1'b0;
                    taken_d = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.load_done) begin
                    taken_d = 1'b0;
                    state_d = (cnt_q != '0) ? S_SORT : S_STORE;
                end else if (bus.load_ready) begin
                    taken_d = 1'b1;
                end
            end
            S_SORT: begin
                if (bus.sort_done) begin
                    // Compare the pre-increment index so count passes run
                    // and pass_idx stops at count without wrapping.
                    pidx_d  = pidx_q + PASS_W'(1);
                    taken_d = 1'b0;
                    if (pidx_q == cnt_q - PASS_W'(1)) begin
                        state_d = S_STORE;
                    end else if (EARLY_EXIT != 0 && !bus.sort_swapped) begin
                        ee_d    = 1'b1;
                        state_d = S_STORE;
                    end
                end else if (bus.sort_ready) begin
                    taken_d = 1'b1;
                end
            end
            S_STORE: begin
                if (bus.store_done) begin
                    taken_d = 1'b0;
                    state_d = S_DONE;
                end else if (bus.store_ready) begin
                    taken_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ap_idle     = (state_q == S_IDLE);
    assign bus.ap_done     = (state_q == S_DONE);
    assign bus.ap_ready    = (state_q == S_DONE);
    assign bus.load_start  = (state_q == S_LOAD) && !taken_q;
    assign bus.sort_start  = (state_q == S_SORT) && !taken_q;
    assign bus.store_start = (state_q == S_STORE) && !taken_q;
    assign bus.pass_idx    = pidx_q;
    assign bus.early_exit  = ee_q;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cc_q, cc_d;

    always_comb begin
        cc_d = cc_q;
        if (state_q == S_IDLE) begin
            if (bus.ap_start) begin
                cc_d = '0;
            end
        end else if (cc_q != '1) begin
            cc_d = cc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cc_q <= '0;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cycle_count = cc_q;
`endif

endmodule

// File: tb/tb_bubble_sort_stage_sequencer.sv
// Directed bench for bubble_sort_stage_sequencer: two instances
// (EARLY_EXIT=1 and 0) driven in lockstep by a 3-cycle child model.
module tb_bubble_sort_stage_sequencer;

    localparam int PW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bubble_sort_stage_sequencer_if #(.PASS_W(PW)) b0 ();
    bubble_sort_stage_sequencer_if #(.PASS_W(PW)) b1 ();

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cc0, cc1;
`endif

    bubble_sort_stage_sequencer #(
        .PASS_W(PW), .EARLY_EXIT(1), .CNT_W(32)
    ) u0 (
        .clock(clock),
        .reset(reset),
        .bus(b0)
`ifdef SEQ_PERF_CNT_EN
        , .cycle_count(cc0)
`endif
    );

    bubble_sort_stage_sequencer #(
        .PASS_W(PW), .EARLY_EXIT(0), .CNT_W(32)
    ) u1 (
        .clock(clock),
        .reset(reset),
        .bus(b1)
`ifdef SEQ_PERF_CNT_EN
        , .cycle_count(cc1)
`endif
    );

    logic          ap_start_r;
    logic [PW-1:0] cnt_r;
    logic          sw_r;
    logic          stall;
    int            tcur;

    // child model: ready and done on the 3rd consecutive cycle of start
    logic [5:0] st;
    logic [5:0] hit;
    logic [1:0] n [6];

    assign st = {b1.store_start, b1.sort_start, b1.load_start,
                 b0.store_start, b0.sort_start, b0.load_start};

    always_comb begin
        hit = '0;
        for (int i = 0; i < 6; i++) begin
            hit[i] = st[i] && (n[i] == 2'd2);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 6; i++) begin
            n[i] <= (reset || !st[i] || hit[i]) ? 2'd0 : n[i] + 2'd1;
        end
    end

    assign b0.ap_start     = ap_start_r;
    assign b0.pass_count   = cnt_r;
    assign b0.sort_swapped = sw_r;
    assign b0.load_ready   = stall ? (tcur == 1)  : hit[0];
    assign b0.load_done    = stall ? (tcur == 12) : hit[0];
    assign b0.sort_ready   = hit[1];
    assign b0.sort_done    = hit[1];
    assign b0.store_ready  = hit[2];
    assign b0.store_done   = hit[2];

    assign b1.ap_start     = ap_start_r;
    assign b1.pass_count   = cnt_r;
    assign b1.sort_swapped = sw_r;
    assign b1.load_ready   = stall ? (tcur == 1)  : hit[3];
    assign b1.load_done    = stall ? (tcur == 12) : hit[3];
    assign b1.sort_ready   = hit[4];
    assign b1.sort_done    = hit[4];
    assign b1.store_ready  = hit[5];
    assign b1.store_done   = hit[5];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input string nm, input int cnt, input bit sw,
                       input int ed0, input int ed1, input int ecalls,
                       input int eld, input bit eee, input int epidx,
                       input int ecc);
        int t, d0, d1, calls, lds, dn, rbad;
        d0 = -1; d1 = -1; calls = 0; lds = 0; dn = 0; rbad = 0;
        chk({nm, "_idle_before"}, 32'(b0.ap_idle), 1);
        ap_start_r = 1'b1;
        cnt_r      = cnt[PW-1:0];
        sw_r       = sw;
        tcur       = 0;
        @(posedge clock);
        for (t = 1; t < 2000 && (d0 < 0 || d1 < 0); t++) begin
            @(negedge clock);
            tcur       = t;
            ap_start_r = 1'b0;
            if (t == 1) begin
                chk({nm, "_ee_clr"}, 32'(b0.early_exit), 0);
            end
            if (b0.ap_done) begin
                dn++;
                if (d0 < 0) d0 = t;
            end
            if (b1.ap_done && d1 < 0) d1 = t;
            if (b0.ap_ready != b0.ap_done) rbad++;
            if (b0.sort_start && b0.sort_done) calls++;
            if (b0.load_start) lds++;
        end
        tcur = 0;
        @(negedge clock);
        chk({nm, "_done0"}, d0, ed0);
        chk({nm, "_done1"}, d1, ed1);
        chk({nm, "_calls"}, calls, ecalls);
        chk({nm, "_loads"}, lds, eld);
        chk({nm, "_pulse"}, dn, 1);
        chk({nm, "_ready"}, rbad, 0);
        chk({nm, "_idle"}, 32'(b0.ap_idle), 1);
        chk({nm, "_ee"}, 32'(b0.early_exit), 32'(eee));
        chk({nm, "_pidx"}, 32'(b0.pass_idx), epidx);
`ifdef SEQ_PERF_CNT_EN
        chk({nm, "_cc"}, cc0, ecc);
`endif
    endtask

    initial begin
        ap_start_r = 1'b0;
        cnt_r      = '0;
        sw_r       = 1'b0;
        stall      = 1'b0;
        tcur       = 0;
        reset      = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_idle", 32'(b0.ap_idle), 1);
        chk("rst_done", 32'(b0.ap_done), 0);
        chk("rst_starts", 32'({b0.load_start, b0.sort_start, b0.store_start}), 0);
        chk("rst_pidx", 32'(b0.pass_idx), 0);
        chk("rst_ee", 32'(b0.early_exit), 0);
        reset = 1'b0;
        @(negedge clock);

        run("s1", 3, 1'b1, 16, 16, 3, 3, 1'b0, 3, 16);
        run("s2", 5, 1'b0, 10, 22, 1, 3, 1'b1, 1, 10);
        chk("ee_sticky", 32'(b0.early_exit), 1);
        run("s3", 0, 1'b1, 7, 7, 0, 3, 1'b0, 0, 7);
        stall = 1'b1;
        run("s4", 3, 1'b1, 25, 25, 3, 1, 1'b0, 3, 25);
        stall = 1'b0;
        run("s5", 1, 1'b1, 10, 10, 1, 3, 1'b0, 1, 10);
        run("s6", 255, 1'b1, 772, 772, 255, 3, 1'b0, 255, 772);

        // ap_start held high across two runs
        ap_start_r = 1'b1;
        cnt_r      = 8'd3;
        sw_r       = 1'b1;
        @(posedge clock);
        for (int t = 1; t <= 40; t++) begin
            @(negedge clock);
            if (t == 16) chk("hold_done16", 32'(b0.ap_done), 1);
            if (t == 17) chk("hold_idle17", 32'(b0.ap_idle), 1);
            if (t == 18) begin
                chk("hold_load18", 32'(b0.load_start), 1);
                ap_start_r = 1'b0;
            end
            if (t == 33) chk("hold_done33", 32'(b0.ap_done), 1);
        end

        // reset during the 2nd SORT pass
        ap_start_r = 1'b1;
        @(posedge clock);
        for (int t = 1; t <= 8; t++) begin
            @(negedge clock);
            ap_start_r = 1'b0;
        end
        chk("mid_pidx", 32'(b0.pass_idx), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mr_starts", 32'({b0.load_start, b0.sort_start, b0.store_start}), 0);
        chk("mr_idle", 32'(b0.ap_idle), 1);
        chk("mr_pidx", 32'(b0.pass_idx), 0);
        chk("mr_ee", 32'(b0.early_exit), 0);
`ifdef SEQ_PERF_CNT_EN
        chk("mr_cc", cc0, 0);
`endif
        @(negedge clock);
        run("s7", 3, 1'b1, 16, 16, 3, 3, 1'b0, 3, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
